// File: rtl/symbol_packer_pkg.sv
// Shared types and constants for the 2-bit symbol packer.
package symbol_packer_pkg;

  localparam int SYM_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    DISCARD = 2'd2
  } packer_state_t;

  // Reset values; the packing register constant is sliced to the word width.
  localparam packer_state_t STATE_RST = IDLE;
  localparam logic [63:0]   PACK_RST  = 64'd0;

endpackage

// File: rtl/symbol_packer_fifo.sv
// Synchronous FIFO with a registered head word. A push on a full FIFO is
// accepted when a pop happens in the same cycle.
module symbol_packer_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 11
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] head_q, head_d;
  logic          nonempty_q, nonempty_d;
  logic          pop_ok;
  logic          push_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

  // Next pointers, occupancy and the word that will sit at the head.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (push_ok ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (pop_ok ? AW'(1) : AW'(0));
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
    head_d = head_q;
    if (pop_ok) begin
      if (count_q > CW'(1)) begin
        head_d = mem_q[rd_ptr_q + AW'(1)];
      end else if (push_ok) begin
        head_d = push_data_i;
      end else begin
        head_d = '0;
      end
    end else if ((count_q == '0) && push_ok) begin
      head_d = push_data_i;
    end
    nonempty_d = (count_d != '0);
  end

  // Storage array, no reset needed: entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Control registers and the registered head.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      nonempty_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      nonempty_q <= nonempty_d;
    end
  end

  assign head_o  = head_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = !nonempty_q;

endmodule

// File: rtl/symbol_packer.sv
// Packs 2-bit symbols into words (first symbol in the LSBs), buffers the
// completed words and hands them out over valid/ready. Partial words are
// closed by flush; a dropped word forces a resync that ends on flush.
module symbol_packer
  import symbol_packer_pkg::*;
#(
  parameter int SYMBOLS_PER_WORD = 4,
  parameter int FIFO_DEPTH       = 4,
  localparam int W  = SYM_W * SYMBOLS_PER_WORD,
  localparam int NW = $clog2(SYMBOLS_PER_WORD + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             sym_valid_i,
  input  logic [SYM_W-1:0] sym_i,
  input  logic             flush_i,
  output logic [W-1:0]     word_o,
  output logic [NW-1:0]    word_nsym_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic [NW-1:0]    fill_o,
  output logic             overflow_o
);

  packer_state_t state_q, state_d;
  logic [W-1:0]  pack_q, pack_d;
  logic [NW-1:0] fill_q, fill_d;
  logic          overflow_q, overflow_d;

  logic [W-1:0]  pack_after;
  logic [NW-1:0] fill_after;
  logic          emit;
  logic [NW-1:0] emit_nsym;
  logic          push;
  logic          pop;
  logic [NW+W-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;

  assign pop = word_valid_o && word_ready_i;

  // Packing register, fill counter and FSM: complete/flush a word, push it
  // or drop it when the FIFO is full without a pop this cycle.
  always_comb begin
    state_d    = state_q;
    pack_d     = pack_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    emit       = 1'b0;
    emit_nsym  = '0;
    pack_after = pack_q;
    fill_after = fill_q;

    if (sym_valid_i) begin
      for (int k = 0; k < SYMBOLS_PER_WORD; k++) begin
        if (fill_q == NW'(k)) begin
          pack_after[SYM_W*k +: SYM_W] = sym_i;
        end
      end
      fill_after = fill_q + NW'(1);
    end

    case (state_q)
      IDLE, FILL: begin
        if (fill_after == NW'(SYMBOLS_PER_WORD)) begin
          emit      = 1'b1;
          emit_nsym = NW'(SYMBOLS_PER_WORD);
        end else if (flush_i && (state_q == FILL)) begin
          emit      = 1'b1;
          emit_nsym = fill_after;
        end

        if (emit) begin
          pack_d = PACK_RST[W-1:0];
          fill_d = '0;
          if (fifo_full && !pop) begin
            overflow_d = 1'b1;
            state_d    = DISCARD;
          end else begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          pack_d  = pack_after;
          fill_d  = fill_after;
          state_d = (fill_after == '0) ? IDLE : FILL;
        end
      end
      DISCARD: begin
        pack_d = PACK_RST[W-1:0];
        fill_d = '0;
        if (flush_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        pack_d  = PACK_RST[W-1:0];
        fill_d  = '0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= STATE_RST;
      pack_q     <= PACK_RST[W-1:0];
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pack_q     <= pack_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

  symbol_packer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (NW + W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (push),
    .push_data_i ({emit_nsym, pack_after}),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign word_o       = head[W-1:0];
  assign word_nsym_o  = head[W +: NW];
  assign word_valid_o = !fifo_empty;
  assign fill_o       = fill_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_symbol_packer.sv
// Randomized and directed bench for symbol_packer against a queue-based
// reference model of the packing and buffering rules.
module tb_symbol_packer;

  localparam int SPW   = 4;
  localparam int DEPTH = 4;
  localparam int W     = 2 * SPW;
  localparam int NW    = $clog2(SPW + 1);

  logic          clk_i;
  logic          rst_n_i;
  logic          sym_valid_i;
  logic [1:0]    sym_i;
  logic          flush_i;
  logic [W-1:0]  word_o;
  logic [NW-1:0] word_nsym_o;
  logic          word_valid_o;
  logic          word_ready_i;
  logic [NW-1:0] fill_o;
  logic          overflow_o;

  symbol_packer #(
    .SYMBOLS_PER_WORD (SPW),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .sym_valid_i  (sym_valid_i),
    .sym_i        (sym_i),
    .flush_i      (flush_i),
    .word_o       (word_o),
    .word_nsym_o  (word_nsym_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .fill_o       (fill_o),
    .overflow_o   (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model state
  typedef struct {
    logic [W-1:0] w;
    int           n;
  } ent_t;

  ent_t       mq[$];
  logic [1:0] part[$];
  bit         m_discard;
  bit         m_ovf;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    part.delete();
    m_discard = 0;
    m_ovf     = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs at the edge.
  task automatic model_edge();
    int   occ;
    bit   pop;
    bit   had;
    bit   emit;
    ent_t e;
    occ = mq.size();
    pop = (occ > 0) && word_ready_i;
    if (pop) begin
      $display("pop word=%02h nsym=%0d", mq[0].w, mq[0].n);
      void'(mq.pop_front());
    end
    if (m_discard) begin
      if (flush_i) m_discard = 0;
    end else begin
      had  = part.size() > 0;
      emit = 0;
      if (sym_valid_i) part.push_back(sym_i);
      if (part.size() == SPW) emit = 1;
      else if (flush_i && had) emit = 1;
      if (emit) begin
        if (occ == DEPTH && !pop) begin
          m_ovf     = 1;
          m_discard = 1;
          $display("drop nsym=%0d", part.size());
        end else begin
          e.w = '0;
          for (int k = 0; k < part.size(); k++) e.w = e.w | (W'(part[k]) << (2 * k));
          e.n = part.size();
          mq.push_back(e);
        end
        part.delete();
      end
    end
  endtask

  task automatic check_all();
    chk("valid", word_valid_o, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("word", word_o, mq[0].w);
      chk("nsym", word_nsym_o, mq[0].n);
    end
    chk("fill", fill_o, part.size());
    chk("overflow", overflow_o, m_ovf);
  endtask

  task automatic step(input bit v, input logic [1:0] s, input bit f, input bit r);
    sym_valid_i  = v;
    sym_i        = s;
    flush_i      = f;
    word_ready_i = r;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic reset_dut();
    sym_valid_i  = 0;
    flush_i      = 0;
    word_ready_i = 0;
    rst_n_i      = 0;
    #1;
    model_clear();
    chk("rst_valid", word_valid_o, 0);
    chk("rst_word", word_o, 0);
    chk("rst_nsym", word_nsym_o, 0);
    chk("rst_fill", fill_o, 0);
    chk("rst_ovf", overflow_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1;
  endtask

  initial begin
    rst_n_i      = 1;
    sym_valid_i  = 0;
    sym_i        = 0;
    flush_i      = 0;
    word_ready_i = 0;
    model_clear();
    #2;
    reset_dut();

    // Full word 01,10,11,00 visible one cycle after the fourth symbol
    step(1, 2'b01, 0, 1);
    step(1, 2'b10, 0, 1);
    step(1, 2'b11, 0, 1);
    chk("tp1_early", word_valid_o, 0);
    step(1, 2'b00, 0, 1);
    chk("tp1_word", word_o, 8'h39);
    chk("tp1_nsym", word_nsym_o, 4);

    // Partial word by flush, then a flush in IDLE that produces nothing
    step(1, 2'b10, 0, 1);
    step(1, 2'b11, 0, 1);
    step(0, 2'b00, 1, 0);
    chk("tp2_word", word_o, 8'h0E);
    chk("tp2_nsym", word_nsym_o, 2);
    chk("tp2_fill", fill_o, 0);
    step(0, 2'b00, 1, 1);
    chk("tp2_noword", word_valid_o, 0);

    // Fourth symbol together with flush: exactly one full word
    step(1, 2'b11, 0, 1);
    step(1, 2'b10, 0, 1);
    step(1, 2'b01, 0, 1);
    step(1, 2'b00, 1, 1);
    chk("tp3_word", word_o, 8'h1B);
    chk("tp3_nsym", word_nsym_o, 4);
    step(0, 2'b00, 0, 1);
    chk("tp3_single", word_valid_o, 0);

    // Five words with no consumer: fifth dropped, then discard until flush
    for (int i = 0; i < 5 * SPW; i++) step(1, 2'($urandom), 0, 0);
    chk("tp4_ovf", overflow_o, 1);
    for (int i = 0; i < 6; i++) step(1, 2'($urandom), 0, 0);
    chk("tp4_discard_fill", fill_o, 0);
    step(1, 2'b11, 1, 0);
    for (int i = 0; i < SPW; i++) step(1, 2'b01, 0, 1);
    chk("tp4_55", word_o, 8'h55);
    step(0, 2'b00, 0, 1);

    // Full FIFO, pop in the cycle a new word completes: no drop
    reset_dut();
    for (int i = 0; i < 4 * SPW + 3; i++) step(1, 2'($urandom), 0, 0);
    step(1, 2'b10, 0, 1);
    chk("tp5_ovf", overflow_o, 0);
    for (int i = 0; i < 6; i++) step(0, 2'b00, 0, 1);

    // Reset with a partial word and queued words, then a fresh word
    for (int i = 0; i < 2 * SPW + 3; i++) step(1, 2'($urandom), 0, 0);
    chk("tp6_fill", fill_o, 3);
    reset_dut();
    for (int i = 0; i < SPW; i++) step(1, 2'($urandom), 0, 1);
    chk("tp6_fresh", word_valid_o, 1);
    step(0, 2'b00, 0, 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) reset_dut();
      step($urandom_range(0, 9) < 7, 2'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
